nonce_result_fifo_xn: RTL and testbench
=======================================

// Module: nonce_result_fifo_xn
// PURPOSE
//  Collects nonce hits from N_CORES hash cores into a DEPTH-entry show-ahead FIFO.
//  Successor to the two-slot nonce catcher; feeds the IRQ/MISO builder.
//  Per-core one-deep capture, round-robin merge, threshold/timeout IRQ,
//  flush on new job, saturating drop counter.
// PARAMETERS
//  N_CORES    4   number of core result inputs (>=2); CW = clog2(N_CORES)
//  DEPTH      8   FIFO entries (power of 2, >=2); AW = clog2(DEPTH)
//  NONCE_W    32  nonce width
//  ID_W       4   hash/job id width
//  IRQ_THRESH 2   fill level that raises irq immediately (1..DEPTH)
//  TIMEOUT    256 cycles a non-empty, unpopped FIFO waits before irq (>=1)
// PORTS
//  clk          in  1                  core clock (pll output)
//  reset_n      in  1                  asynchronous, active-low reset
//  core_success in  N_CORES            per-core 1-cycle hit strobe
//  core_nonce   in  N_CORES*NONCE_W    per-core nonce; core k at [k*NONCE_W +: NONCE_W]
//  core_hash_id in  N_CORES*ID_W       per-core job id; same slicing
//  flush        in  1                  drop all stored and pending results
//  rd_pop       in  1                  consume head entry
//  rd_valid     out 1                  FIFO non-empty
//  rd_data      out CW+ID_W+NONCE_W    head entry {core_idx, hash_id, nonce}
//  fill_level   out AW+1               entries stored, 0..DEPTH
//  irq          out 1                  registered interrupt request
//  overflow_cnt out 8                  dropped hits, saturates at 255
// BEHAVIOUR
//  Reset: all outputs 0. FIFO, pendings, age counter empty/0. RR pointer = core 0.
//  Capture: edge t samples core_success[k] into pend[k] with its nonce and id.
//   Pending slot full and not granted this cycle -> new hit dropped,
//   overflow_cnt += 1 (saturating). Granted this cycle -> new hit accepted.
//  Arbiter: each cycle, FIFO not full or rd_pop this cycle -> grant one pend[k].
//   Search starts at RR pointer; after grant to k, pointer = (k+1) mod N_CORES.
//   Grant writes {k, id, nonce} at wr_ptr and clears pend[k].
//  Latency: success at edge t -> rd_valid/rd_data valid after edge t+1 (2 cycles).
//  FIFO full, no pop: pendings hold (backpressure), not dropped.
//   Drops happen only on pending-slot collision.
//  Pop: rd_pop with rd_valid=1 advances rd_ptr. rd_pop with rd_valid=0 is ignored.
//   Push+pop same cycle: fill_level unchanged. Legal at full and when fill=1.
//  Pointers wrap mod DEPTH. fill_level tracks pushes minus pops exactly.
//  rd_data is registered head storage, valid whenever rd_valid=1; undefined otherwise.
//  Flush (priority over everything): next edge empties FIFO and clears all pendings.
//   Same-cycle success and pop are discarded. RR pointer -> 0. age -> 0. irq -> 0.
//   overflow_cnt is kept; only reset clears it.
//  Age: counts cycles while fill_level!=0. Cleared on any accepted pop or when empty.
//   Saturates at TIMEOUT.
//  irq (registered): next = fill_level>=IRQ_THRESH || (fill_level!=0 && age==TIMEOUT).
//   Drops the cycle after the FIFO empties.
//  Reset mid-operation: immediate clear, no partial entry survives.
// TESTING
//  Core2 hit, nonce=32'hDEADBEEF, id=4'h5 -> rd_valid 2 cycles later.
//   rd_data={2'd2,4'h5,32'hDEADBEEF}, fill=1, irq=0.
//  All 4 cores hit in the same cycle -> 4 entries in order 0,1,2,3.
//   fill=4, irq after fill>=2, overflow_cnt=0.
//  Core1 hits on 2 consecutive cycles with FIFO full, no pop.
//   -> overflow_cnt=1, pending entry written after the first pop.
//  Single entry never popped -> irq rises TIMEOUT+1 cycles after it is stored.
//   Pop -> irq falls the next cycle.
//  Fill to DEPTH=8, then pop+success same cycle -> fill stays 8.
//   FIFO order preserved across pointer wrap.
//  flush asserted together with a success and a pop at fill=5.
//   -> fill=0, rd_valid=0, irq=0. overflow_cnt unchanged.

Source files
------------

// File: rtl/nonce_result_fifo_xn_if.sv
// nonce_result_fifo_xn_if: hit inputs and show-ahead read side of the nonce result FIFO
//   master: drives core_success, core_nonce, core_hash_id, flush, rd_pop
//   slave : drives rd_valid, rd_data {core_idx, hash_id, nonce}, fill_level, irq, overflow_cnt
interface nonce_result_fifo_xn_if #(
   parameter int N_CORES = 4,
   parameter int DEPTH   = 8,
   parameter int NONCE_W = 32,
   parameter int ID_W    = 4
);
   localparam int CW = $clog2(N_CORES);
   localparam int AW = $clog2(DEPTH);
   logic [N_CORES-1:0]         core_success;
   logic [N_CORES*NONCE_W-1:0] core_nonce;
   logic [N_CORES*ID_W-1:0]    core_hash_id;
   logic                       flush;
   logic                       rd_pop;
   logic                       rd_valid;
   logic [CW+ID_W+NONCE_W-1:0] rd_data;
   logic [AW:0]                fill_level;
   logic                       irq;
   logic [7:0]                 overflow_cnt;
   modport master (
      output core_success, core_nonce, core_hash_id, flush, rd_pop,
      input  rd_valid, rd_data, fill_level, irq, overflow_cnt
   );
   modport slave (
      input  core_success, core_nonce, core_hash_id, flush, rd_pop,
      output rd_valid, rd_data, fill_level, irq, overflow_cnt
   );
endinterface

// File: rtl/nonce_result_fifo_xn.sv
// nonce_result_fifo_xn: per-core hit capture, round-robin merge into a show-ahead FIFO with irq
//   clk     : core clock
//   reset_n : asynchronous active-low reset
//   bus     : slave side of nonce_result_fifo_xn_if (core hits, flush, pop, FIFO status, irq)
module nonce_result_fifo_xn #(
   parameter int N_CORES    = 4,
   parameter int DEPTH      = 8,
   parameter int NONCE_W    = 32,
   parameter int ID_W       = 4,
   parameter int IRQ_THRESH = 2,
   parameter int TIMEOUT    = 256
) (
   input logic                   clk,
   input logic                   reset_n,
   nonce_result_fifo_xn_if.slave bus
);
   localparam int CW = $clog2(N_CORES);
   localparam int AW = $clog2(DEPTH);
   localparam int EW = CW + ID_W + NONCE_W;
   localparam int GW = $clog2(TIMEOUT + 1);
   logic [N_CORES-1:0] r_pend_v;
   logic [NONCE_W-1:0] r_pend_nonce [N_CORES];
   logic [ID_W-1:0]    r_pend_id    [N_CORES];
   logic [EW-1:0]      r_mem        [DEPTH];
   logic [AW-1:0]      r_wr_ptr;
   logic [AW-1:0]      r_rd_ptr;
   logic [AW:0]        r_fill;
   logic [CW-1:0]      r_rr;
   logic [GW-1:0]      r_age;
   logic               r_irq;
   logic [7:0]         r_ovf;
   logic               w_pop;
   logic               w_can_push;
   logic               w_gnt_v;
   logic [CW-1:0]      w_gnt_k;
   logic [N_CORES-1:0] w_gsel;
   logic [N_CORES-1:0] w_take;
   logic [N_CORES-1:0] w_drop;
   logic [CW:0]        w_ndrop;
   logic [8:0]         w_ovf_sum;
   logic [AW:0]        w_fill_nxt;
   logic [GW-1:0]      w_age_nxt;
   logic               w_irq_nxt;
   assign w_pop      = bus.rd_pop && (r_fill != '0);
   assign w_can_push = (r_fill != (AW+1)'(DEPTH)) || w_pop;
   // Descending scan so the slot closest to the RR pointer is the last (winning) assignment.
   always_comb begin
      w_gnt_v = 1'b0;
      w_gnt_k = '0;
      for (int i = N_CORES - 1; i >= 0; i--) begin
         if (w_can_push && r_pend_v[(int'(r_rr) + i) % N_CORES]) begin
            w_gnt_v = 1'b1;
            w_gnt_k = CW'((int'(r_rr) + i) % N_CORES);
         end
      end
   end
   assign w_gsel = N_CORES'(w_gnt_v) << w_gnt_k;
   // A slot being granted this cycle frees up in time to take a new hit.
   assign w_take = ~r_pend_v | w_gsel;
   assign w_drop = bus.core_success & ~w_take;
   always_comb begin
      w_ndrop = '0;
      for (int k = 0; k < N_CORES; k++)
         w_ndrop = w_ndrop + (CW+1)'(w_drop[k]);
   end
   assign w_ovf_sum  = {1'b0, r_ovf} + 9'(w_ndrop);
   assign w_fill_nxt = r_fill + (AW+1)'(w_gnt_v) - (AW+1)'(w_pop);
   assign w_age_nxt  = (w_pop || r_fill == '0) ? '0 :
                       (r_age == GW'(TIMEOUT)) ? r_age : r_age + GW'(1);
   assign w_irq_nxt  = (r_fill >= (AW+1)'(IRQ_THRESH)) ||
                       (r_fill != '0 && r_age == GW'(TIMEOUT));
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pend_v <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_fill   <= '0;
         r_rr     <= '0;
         r_age    <= '0;
         r_irq    <= 1'b0;
         r_ovf    <= '0;
         for (int k = 0; k < N_CORES; k++) begin
            r_pend_nonce[k] <= '0;
            r_pend_id[k]    <= '0;
         end
         for (int d = 0; d < DEPTH; d++)
            r_mem[d] <= '0;
      end else if (bus.flush) begin
         r_pend_v <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_fill   <= '0;
         r_rr     <= '0;
         r_age    <= '0;
         r_irq    <= 1'b0;
      end else begin
         if (w_gnt_v) begin
            r_mem[r_wr_ptr] <= {w_gnt_k, r_pend_id[w_gnt_k], r_pend_nonce[w_gnt_k]};
            r_wr_ptr        <= r_wr_ptr + AW'(1);
            r_rr            <= (w_gnt_k == CW'(N_CORES - 1)) ? '0 : w_gnt_k + CW'(1);
         end
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + AW'(1);
         r_pend_v <= (r_pend_v & ~w_gsel) | (bus.core_success & w_take);
         for (int k = 0; k < N_CORES; k++) begin
            if (bus.core_success[k] && w_take[k]) begin
               r_pend_nonce[k] <= bus.core_nonce[k*NONCE_W +: NONCE_W];
               r_pend_id[k]    <= bus.core_hash_id[k*ID_W +: ID_W];
            end
         end
         r_fill <= w_fill_nxt;
         r_age  <= w_age_nxt;
         r_irq  <= w_irq_nxt;
         r_ovf  <= w_ovf_sum[8] ? 8'hFF : w_ovf_sum[7:0];
      end
   end
   assign bus.rd_valid     = r_fill != '0;
   assign bus.rd_data      = r_mem[r_rd_ptr];
   assign bus.fill_level   = r_fill;
   assign bus.irq          = r_irq;
   assign bus.overflow_cnt = r_ovf;
endmodule

// File: tb/tb_nonce_result_fifo_xn.sv
// tb_nonce_result_fifo_xn: table vectors, directed corner sequences and random traffic against a queue model
module tb_nonce_result_fifo_xn;
   localparam int N   = 4;
   localparam int D   = 8;
   localparam int NW  = 32;
   localparam int IW  = 4;
   localparam int THR = 2;
   localparam int TO  = 256;
   localparam int EW  = 2 + IW + NW;
   typedef struct {
      logic [3:0] succ;
      logic       pop;
      logic [3:0] fill;
      logic       irq;
   } vec_t;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;
   nonce_result_fifo_xn_if #(.N_CORES(N), .DEPTH(D), .NONCE_W(NW), .ID_W(IW)) bus ();
   nonce_result_fifo_xn #(
      .N_CORES(N), .DEPTH(D), .NONCE_W(NW), .ID_W(IW), .IRQ_THRESH(THR), .TIMEOUT(TO)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus)
   );
   int checks = 0;
   int failures = 0;
   logic [EW-1:0] q[$];
   bit            mp_v [N];
   logic [NW-1:0] mp_n [N];
   logic [IW-1:0] mp_id[N];
   int            m_rr, m_age, m_ovf;
   bit            m_irq;
   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic model_reset();
      q.delete();
      foreach (mp_v[k]) mp_v[k] = 1'b0;
      m_rr = 0;
      m_age = 0;
      m_irq = 1'b0;
      m_ovf = 0;
   endtask
   task automatic model_step();
      int g;
      int sz;
      bit pop;
      if (bus.flush) begin
         q.delete();
         foreach (mp_v[k]) mp_v[k] = 1'b0;
         m_rr = 0;
         m_age = 0;
         m_irq = 1'b0;
         return;
      end
      sz = q.size();
      pop = bus.rd_pop && sz != 0;
      g = -1;
      if (sz < D || pop)
         for (int i = 0; i < N; i++)
            if (g < 0 && mp_v[(m_rr + i) % N]) g = (m_rr + i) % N;
      m_irq = sz >= THR || (sz != 0 && m_age == TO);
      m_age = (pop || sz == 0) ? 0 : (m_age < TO ? m_age + 1 : TO);
      if (pop) void'(q.pop_front());
      if (g >= 0) begin
         q.push_back({2'(g), mp_id[g], mp_n[g]});
         mp_v[g] = 1'b0;
         m_rr = (g + 1) % N;
      end
      for (int k = 0; k < N; k++) begin
         if (bus.core_success[k]) begin
            if (mp_v[k]) m_ovf = m_ovf < 255 ? m_ovf + 1 : 255;
            else begin
               mp_v[k] = 1'b1;
               mp_n[k] = bus.core_nonce[k*NW +: NW];
               mp_id[k] = bus.core_hash_id[k*IW +: IW];
            end
         end
      end
   endtask
   task automatic compare();
      chk("rd_valid", 64'(bus.rd_valid), 64'(q.size() != 0));
      chk("fill_level", 64'(bus.fill_level), 64'(q.size()));
      chk("irq", 64'(bus.irq), 64'(m_irq));
      chk("overflow_cnt", 64'(bus.overflow_cnt), 64'(m_ovf));
      if (q.size() != 0) chk("rd_data", 64'(bus.rd_data), 64'(q[0]));
   endtask
   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      compare();
   endtask
   task automatic set_core(int k, logic [NW-1:0] nonce, logic [IW-1:0] id);
      bus.core_nonce[k*NW +: NW] = nonce;
      bus.core_hash_id[k*IW +: IW] = id;
   endtask
   task automatic idle_inputs();
      bus.core_success = '0;
      bus.flush = 1'b0;
      bus.rd_pop = 1'b0;
   endtask
   task automatic chk_zero(string tag);
      chk({tag, "_rd_valid"}, 64'(bus.rd_valid), 64'd0);
      chk({tag, "_rd_data"}, 64'(bus.rd_data), 64'd0);
      chk({tag, "_fill"}, 64'(bus.fill_level), 64'd0);
      chk({tag, "_irq"}, 64'(bus.irq), 64'd0);
      chk({tag, "_ovf"}, 64'(bus.overflow_cnt), 64'd0);
   endtask
   task automatic do_reset();
      idle_inputs();
      #2 reset_n = 1'b0;
      #1 chk_zero("async_rst");
      @(posedge clk);
      #1 reset_n = 1'b1;
      model_reset();
   endtask
   initial begin
      vec_t tbl[16];
      tbl[0]  = '{4'b1111, 1'b0, 4'd0, 1'b0};
      tbl[1]  = '{4'b0000, 1'b0, 4'd1, 1'b0};
      tbl[2]  = '{4'b0000, 1'b0, 4'd2, 1'b0};
      tbl[3]  = '{4'b0000, 1'b0, 4'd3, 1'b1};
      tbl[4]  = '{4'b0000, 1'b0, 4'd4, 1'b1};
      tbl[5]  = '{4'b0000, 1'b1, 4'd3, 1'b1};
      tbl[6]  = '{4'b0000, 1'b1, 4'd2, 1'b1};
      tbl[7]  = '{4'b0000, 1'b1, 4'd1, 1'b1};
      tbl[8]  = '{4'b0000, 1'b1, 4'd0, 1'b0};
      tbl[9]  = '{4'b0000, 1'b0, 4'd0, 1'b0};
      tbl[10] = '{4'b0010, 1'b0, 4'd0, 1'b0};
      tbl[11] = '{4'b0010, 1'b0, 4'd1, 1'b0};
      tbl[12] = '{4'b0000, 1'b0, 4'd2, 1'b0};
      tbl[13] = '{4'b0000, 1'b1, 4'd1, 1'b1};
      tbl[14] = '{4'b0000, 1'b1, 4'd0, 1'b0};
      tbl[15] = '{4'b0000, 1'b0, 4'd0, 1'b0};
      bus.core_nonce = '0;
      bus.core_hash_id = '0;
      idle_inputs();
      model_reset();
      repeat (2) @(posedge clk);
      #1 chk_zero("reset");
      reset_n = 1'b1;
      for (int k = 0; k < N; k++) set_core(k, 32'hC0DE0000 + 32'(k), 4'(k + 8));
      for (int i = 0; i < 16; i++) begin
         bus.core_success = tbl[i].succ;
         bus.rd_pop = tbl[i].pop;
         tick();
         chk($sformatf("tbl%0d_fill", i), 64'(bus.fill_level), 64'(tbl[i].fill));
         chk($sformatf("tbl%0d_irq", i), 64'(bus.irq), 64'(tbl[i].irq));
         chk($sformatf("tbl%0d_ovf", i), 64'(bus.overflow_cnt), 64'd0);
      end
      idle_inputs();
      set_core(2, 32'hDEADBEEF, 4'h5);
      bus.core_success = 4'b0100;
      tick();
      bus.core_success = '0;
      chk("core2_lat1_valid", 64'(bus.rd_valid), 64'd0);
      tick();
      chk("core2_valid", 64'(bus.rd_valid), 64'd1);
      chk("core2_data", 64'(bus.rd_data), 64'({2'd2, 4'h5, 32'hDEADBEEF}));
      chk("core2_fill", 64'(bus.fill_level), 64'd1);
      chk("core2_irq", 64'(bus.irq), 64'd0);
      repeat (TO) tick();
      chk("timeout_irq_before", 64'(bus.irq), 64'd0);
      tick();
      chk("timeout_irq_rise", 64'(bus.irq), 64'd1);
      bus.rd_pop = 1'b1;
      tick();
      bus.rd_pop = 1'b0;
      chk("timeout_pop_valid", 64'(bus.rd_valid), 64'd0);
      chk("timeout_pop_irq", 64'(bus.irq), 64'd1);
      tick();
      chk("timeout_irq_fall", 64'(bus.irq), 64'd0);
      do_reset();
      for (int i = 0; i < 8; i++) begin
         set_core(0, 32'h1000 + 32'(i), 4'h3);
         bus.core_success = 4'b0001;
         tick();
      end
      bus.core_success = '0;
      repeat (2) tick();
      chk("full_fill", 64'(bus.fill_level), 64'd8);
      set_core(1, 32'h11111111, 4'h9);
      bus.core_success = 4'b0010;
      tick();
      set_core(1, 32'h22222222, 4'h9);
      tick();
      bus.core_success = '0;
      tick();
      chk("collide_ovf", 64'(bus.overflow_cnt), 64'd1);
      chk("collide_fill", 64'(bus.fill_level), 64'd8);
      bus.rd_pop = 1'b1;
      tick();
      chk("full_pushpop_fill", 64'(bus.fill_level), 64'd8);
      repeat (7) tick();
      chk("pending_after_pop", 64'(bus.rd_data), 64'({2'd1, 4'h9, 32'h11111111}));
      chk("pending_fill", 64'(bus.fill_level), 64'd1);
      tick();
      bus.rd_pop = 1'b0;
      chk("drain_fill", 64'(bus.fill_level), 64'd0);
      for (int i = 0; i < 5; i++) begin
         set_core(0, 32'h2000 + 32'(i), 4'h4);
         bus.core_success = 4'b0001;
         tick();
      end
      bus.core_success = '0;
      tick();
      chk("preflush_fill", 64'(bus.fill_level), 64'd5);
      bus.flush = 1'b1;
      bus.core_success = 4'b1111;
      bus.rd_pop = 1'b1;
      tick();
      idle_inputs();
      chk("flush_fill", 64'(bus.fill_level), 64'd0);
      chk("flush_valid", 64'(bus.rd_valid), 64'd0);
      chk("flush_irq", 64'(bus.irq), 64'd0);
      chk("flush_ovf", 64'(bus.overflow_cnt), 64'd1);
      repeat (2) tick();
      chk("postflush_fill", 64'(bus.fill_level), 64'd0);
      for (int c = 0; c < 3000; c++) begin
         for (int k = 0; k < N; k++) set_core(k, $urandom, 4'($urandom));
         bus.core_success = 4'($urandom & $urandom);
         bus.rd_pop = (c < 1500) ? ($urandom_range(7) == 0) : ($urandom_range(3) != 0);
         bus.flush = $urandom_range(199) == 0;
         tick();
         if (c == 2200) do_reset();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
